// File: rtl/imm_ctrl_pkg.sv
// Shared types, ALU/opcode encodings and opcode decode helpers for the
// I-type immediate sequencer.
package imm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXTEND = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } ext_mode_t;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD    = 3'b000;
    localparam alu_op_t ALU_SLT    = 3'b001;
    localparam alu_op_t ALU_AND    = 3'b010;
    localparam alu_op_t ALU_OR     = 3'b011;
    localparam alu_op_t ALU_XOR    = 3'b100;
    localparam alu_op_t ALU_PASS_B = 3'b101;

    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ext_mode_t ext_mode_for(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_SLTI:          return EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:  return EXT_ZERO;
            OP_LUI:                    return EXT_UPPER;
            default:                   return EXT_SIGN;
        endcase
    endfunction

    function automatic alu_op_t alu_op_for(input logic [5:0] op);
        case (op)
            OP_ADDI: return ALU_ADD;
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            OP_LUI:  return ALU_PASS_B;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/imm_extender.sv
// Combinational immediate extender: sign-, zero- or upper-placement of the
// immediate field into a DATA_W operand.
module imm_extender
    import imm_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm16_i,
    input  ext_mode_t         ext_mode_i,
    output logic [DATA_W-1:0] imm_ext_o
);

    localparam int PAD_W = DATA_W - IMM_W;

    // UPPER places the immediate in the most significant bits
    always_comb begin
        imm_ext_o = {DATA_W{1'b0}};
        case (ext_mode_i)
            EXT_SIGN:  imm_ext_o = {{PAD_W{imm16_i[IMM_W-1]}}, imm16_i};
            EXT_ZERO:  imm_ext_o = {{PAD_W{1'b0}}, imm16_i};
            EXT_UPPER: imm_ext_o = {imm16_i, {PAD_W{1'b0}}};
            default:   imm_ext_o = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/imm_exec_ctrl.sv
// Multicycle sequencer for I-type immediate instructions: decode, extend,
// execute on the shared ALU, write back to the register file.
module imm_exec_ctrl
    import imm_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [IMM_W-1:0]  imm16,
    output logic [4:0]        rs_addr,
    input  logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    state_t             state_q, state_d;
    logic [5:0]         opcode_q;
    logic [4:0]         rs_q;
    logic [4:0]         rt_q;
    logic [IMM_W-1:0]   imm_q;
    ext_mode_t          ext_mode_q, ext_mode_d;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  alu_out_q;
    logic [DATA_W-1:0]  imm_ext_s;

    imm_extender #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_ext (
        .imm16_i    (imm_q),
        .ext_mode_i (ext_mode_q),
        .imm_ext_o  (imm_ext_s)
    );

    // State and datapath registers; each stage loads only in its own state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            opcode_q   <= 6'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            imm_q      <= {IMM_W{1'b0}};
            ext_mode_q <= EXT_SIGN;
            a_q        <= {DATA_W{1'b0}};
            b_q        <= {DATA_W{1'b0}};
            alu_out_q  <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ext_mode_q <= ext_mode_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        opcode_q <= opcode;
                        rs_q     <= rs;
                        rt_q     <= rt;
                        imm_q    <= imm16;
                    end
                end
                ST_EXTEND: begin
                    a_q <= rs_data;
                    b_q <= imm_ext_s;
                end
                ST_EXEC: begin
                    alu_out_q <= alu_result;
                end
                default: ;
            endcase
        end
    end

    // Next state and outputs, decoded from registered state and fields only
    always_comb begin
        state_d    = state_q;
        ext_mode_d = ext_mode_q;
        rs_addr    = 5'd0;
        alu_a      = {DATA_W{1'b0}};
        alu_b      = {DATA_W{1'b0}};
        alu_op     = 3'd0;
        rf_we      = 1'b0;
        rf_waddr   = 5'd0;
        rf_wdata   = {DATA_W{1'b0}};
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                rs_addr = rs_q;
                if (opcode_legal(opcode_q)) begin
                    ext_mode_d = ext_mode_for(opcode_q);
                    state_d    = ST_EXTEND;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXTEND: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_op  = alu_op_for(opcode_q);
                state_d = ST_WB;
            end
            ST_WB: begin
                // r0 is hardwired: the write is dropped but completion still signals
                rf_we    = (rt_q != 5'd0);
                rf_waddr = rt_q;
                rf_wdata = alu_out_q;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/imm_exec_ctrl.md
# imm_exec_ctrl

Multicycle sequencer for I-type immediate instructions (ADDI, SLTI, ANDI, ORI, XORI, LUI) in the RISC core. It latches the instruction fields and configures the immediate extender per opcode. It then walks the shared ALU and register-file write port through decode, extend, execute and writeback, and signals completion to the main control unit.

## Interface
Parameters:
- DATA_W, 32, datapath width
- IMM_W, 16, immediate field width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; instruction fields valid this cycle
- opcode  in  6  instruction [31:26]
- rs  in  5  source register index
- rt  in  5  destination register index
- imm16  in  IMM_W  immediate field
- rs_addr  out  5  register-file read address
- rs_data  in  DATA_W  register-file read data, valid one cycle after rs_addr
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_op  out  3  ALU function select
- alu_result  in  DATA_W  ALU result, combinational from alu_a/alu_b/alu_op
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  DATA_W  write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- FSM states: IDLE, DECODE, EXTEND, EXEC, WB.
- IDLE: on start, latch opcode/rs/rt/imm16 into internal registers and go to DECODE. start is ignored in every other state (no queueing).
- DECODE: drive rs_addr = latched rs and select ext_mode:
  - ADDI 0x08, SLTI 0x0A: SIGN (imm16[15] replicated into [31:16])
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: ZERO ({16'h0, imm16})
  - LUI 0x0F: UPPER ({imm16, 16'h0})
  - Any other opcode: pulse illegal, go to IDLE; no write, no done.
- EXTEND: register A <= rs_data and B <= extended immediate.
- EXEC: drive alu_a = A, alu_b = B and alu_op (ADD, SLT, AND, OR, XOR, PASS_B for LUI). Register ALUOut <= alu_result.
- WB: rf_waddr = rt and rf_wdata = ALUOut. rf_we = 1 unless rt == 0; writes to r0 are suppressed. done = 1, then go to IDLE.
- SLT is signed; ADD wraps modulo 2^32 with no overflow trap.

## Timing
- Reset (synchronous): state = IDLE. All outputs 0: busy, done, illegal, rf_we, rs_addr, alu_a, alu_b, alu_op, rf_waddr, rf_wdata. Internal registers also clear to 0.
- Reset asserted in any state wins over all transitions. An in-flight instruction is abandoned with no rf_we and no done.
- start in cycle T (IDLE) gives DECODE at T+1, EXTEND at T+2, EXEC at T+3, WB at T+4. done and rf_we are high in T+4 only.
- Earliest next accepted start is T+5, since IDLE returns in T+5 and busy is low from T+5.
- Illegal opcode: illegal high in T+1, busy low from T+2.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path.
- rf_we, done and illegal are never high simultaneously.

## Structure
- Package imm_ctrl_pkg holds:
  - state enum
  - ext_mode_t enum (SIGN, ZERO, UPPER)
  - alu_op_t constants: ADD=000, SLT=001, AND=010, OR=011, XOR=100, PASS_B=101
  - opcode localparams
- Sub-module imm_extender: combinational, inputs imm16 and ext_mode, output DATA_W. The controller instantiates it once and owns the mode select.

## Test plan
- Reset mid-EXEC, during an ADDI started 3 cycles earlier -> next cycle busy=0; no rf_we and no done afterwards.
- ADDI with rs_data=0x0000_0005, imm16=0xFFFE, rt=3 -> T+4: rf_we=1, rf_waddr=3, rf_wdata=0x0000_0003, done=1. T+5: busy=0.
- ORI with rs_data=0x1234_0000, imm16=0x8001, rt=7 -> rf_wdata=0x1234_8001 (zero-extended, not sign-extended).
- LUI with imm16=0xABCD, rt=9 -> rf_wdata=0xABCD_0000. SLTI with rs_data=0xFFFF_FFFF, imm16=0x0001 -> rf_wdata=1.
- Opcode 0x3F -> illegal=1 at T+1, busy=0 at T+2; rf_we and done stay 0. ADDI with rt=0 -> done=1 at T+4, rf_we=0.
- start held high for 6 consecutive cycles with ANDI -> exactly one instruction completes (done at T+4). A second instruction is accepted at T+5 and completes at T+9.
